// File: rtl/fetch_queue_unit_if.sv
// Fetch-queue bus bundle: I-cache request/response, redirect, and decode dequeue port.
// slave = the fetch queue itself; master = the surrounding core / I-cache side.
interface fetch_queue_unit_if #(
  parameter int AW    = 16,
  parameter int IW    = 16,
  parameter int DEPTH = 4
);
  logic [AW-1:0]                i_addr;
  logic                         i_hit;
  logic [IW-1:0]                instr;
  logic                         redirect;
  logic [AW-1:0]                redirect_pc;
  logic                         deq_ready;
  logic                         deq_valid;
  logic [IW-1:0]                deq_instr;
  logic [AW-1:0]                deq_pc;
  logic [$clog2(DEPTH+1)-1:0]   q_count;

  modport slave (
    output i_addr, deq_valid, deq_instr, deq_pc, q_count,
    input  i_hit, instr, redirect, redirect_pc, deq_ready
  );

  modport master (
    input  i_addr, deq_valid, deq_instr, deq_pc, q_count,
    output i_hit, instr, redirect, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch address generator feeding a first-word-fall-through queue toward decode.
// Optional macro IFU_PERF_EN adds saturating miss/redirect performance counters.
module fetch_queue_unit #(
  parameter int            AW       = 16,
  parameter int            IW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_queue_unit_if.slave     bus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]           perf_miss_cnt,
  output logic [31:0]           perf_redirect_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [AW-1:0]    r_pc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [IW-1:0]    r_mem_instr [DEPTH];
  logic [AW-1:0]    r_mem_pc    [DEPTH];

  logic w_deq;
  logic w_slot_open;
  logic w_enq;

  // A redirect squashes both the presented head and any concurrent hit.
  assign w_deq       = (r_count != '0) && bus.deq_ready && !bus.redirect;
  assign w_slot_open = (r_count < CNT_W'(DEPTH)) || w_deq;
  assign w_enq       = !bus.redirect && w_slot_open && bus.i_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.redirect) begin
      r_pc    <= bus.redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_pc   <= r_pc + AW'(1);
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; occupancy is tracked by the control registers above.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_instr[r_tail] <= bus.instr;
      r_mem_pc[r_tail]    <= r_pc;
    end
  end

  assign bus.i_addr    = r_pc;
  assign bus.q_count   = r_count;
  assign bus.deq_valid = (r_count != '0);
  assign bus.deq_instr = r_mem_instr[r_head];
  assign bus.deq_pc    = r_mem_pc[r_head];

`ifdef IFU_PERF_EN
  logic [31:0] r_miss_cnt;
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_cnt     <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (bus.redirect) begin
        r_redirect_cnt <= sat_inc32(r_redirect_cnt);
      end
      if (!bus.redirect && w_slot_open && !bus.i_hit) begin
        r_miss_cnt <= sat_inc32(r_miss_cnt);
      end
    end
  end

  assign perf_miss_cnt     = r_miss_cnt;
  assign perf_redirect_cnt = r_redirect_cnt;
`endif

endmodule
